lsu: RTL and testbench

Load/store stage sitting directly downstream of the execute unit. It accepts one execute result per transaction, passes non-memory results straight to writeback, and for loads and stores runs a request/response handshake on the data bus. Returned load data is lane-aligned and sign- or zero-extended. It then presents a single-cycle writeback beat to the register-file write port.

---
 rtl/lsu.sv | 210 +++++++++++++++++++++
 tb/tb_lsu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu - load/store stage downstream of the execute unit.
//
// Accepts one execute result per transaction while idle. Non-memory results
// go straight to a one-cycle writeback beat. Loads and stores run one
// request/response handshake on the data bus. Load data is lane-aligned and
// then sign- or zero-extended before the writeback beat.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN.
//   Defined   : a misaligned memory op raises misalign and issues no bus request.
//   Undefined : misalign stays 0; misaligned accesses are issued unchanged.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   in_valid / in_ready             execute result handshake (ready only in IDLE)
//   alu_out, store_data             effective address or result, store operand
//   mem_rd, mem_wr, mem_size,
//   mem_unsigned, rd, wb_en_in      instruction attributes
//   dreq_*                          data-bus request channel
//   dresp_valid, dresp_data         data-bus response channel
//   wb_valid, wb_en, wb_rd,
//   wb_data, misalign               register-file writeback beat
module lsu #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [RD_W-1:0] rd,
  input  logic            wb_en_in,
  output logic            dreq_valid,
  input  logic            dreq_ready,
  output logic [XLEN-1:0] dreq_addr,
  output logic            dreq_write,
  output logic [1:0]      dreq_size,
  output logic [XLEN-1:0] dreq_wdata,
  output logic [7:0]      dreq_strobe,
  input  logic            dresp_valid,
  input  logic [XLEN-1:0] dresp_data,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] wbdata_q, wbdata_d;
  logic [7:0]      strobe_q, strobe_d;
  logic [1:0]      size_q, size_d;
  logic            write_q, write_d;
  logic            uns_q, uns_d;
  logic            wben_q, wben_d;
  logic            mis_q, mis_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            in_misaligned;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] load_ext;
  logic            sign_bit;

`ifdef LSU_MISALIGN_CHECK_EN
  // (1 << size) - 1 in 3 bits: for size 3 the shift wraps to 0 and the
  // subtraction wraps to 3'b111, which is exactly the doubleword mask.
  assign in_misaligned = (mem_rd | mem_wr) &&
                         ((alu_out[2:0] & ((3'd1 << mem_size) - 3'd1)) != 3'd0);
`else
  assign in_misaligned = 1'b0;
`endif

  // Byte-enable pattern for an aligned access of the incoming size.
  always_comb begin
    size_mask = 8'hFF;
    case (mem_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Lane-align the returned word, then extend from the access size.
  always_comb begin
    raw      = dresp_data >> {addr_q[2:0], 3'b000};
    sign_bit = 1'b0;
    load_ext = raw;
    case (size_q)
      2'd0: begin
        sign_bit = ~uns_q & raw[7];
        load_ext = {{(XLEN-8){sign_bit}}, raw[7:0]};
      end
      2'd1: begin
        sign_bit = ~uns_q & raw[15];
        load_ext = {{(XLEN-16){sign_bit}}, raw[15:0]};
      end
      2'd2: begin
        sign_bit = ~uns_q & raw[31];
        load_ext = {{(XLEN-32){sign_bit}}, raw[31:0]};
      end
      default: load_ext = raw;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbdata_d = wbdata_q;
    strobe_d = strobe_q;
    size_d   = size_q;
    write_d  = write_q;
    uns_d    = uns_q;
    wben_d   = wben_q;
    mis_d    = mis_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d   = alu_out;
          size_d   = mem_size;
          uns_d    = mem_unsigned;
          rd_d     = rd;
          write_d  = mem_wr;   // store wins when both rd and wr are set
          // Shifted copies keep only what lands inside the 8-byte lane.
          wdata_d  = store_data << {alu_out[2:0], 3'b000};
          strobe_d = size_mask << alu_out[2:0];
          mis_d    = in_misaligned;
          if (in_misaligned) begin
            wben_d   = 1'b0;
            wbdata_d = alu_out;
            state_d  = DONE;
          end else if (mem_rd | mem_wr) begin
            wben_d   = mem_wr ? 1'b0 : wb_en_in;
            wbdata_d = '0;
            state_d  = REQ;
          end else begin
            wben_d   = wb_en_in;
            wbdata_d = alu_out;
            state_d  = DONE;
          end
        end
      end
      REQ: begin
        if (dreq_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dresp_valid) begin
          if (!write_q) wbdata_d = load_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbdata_q <= '0;
      strobe_q <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      wben_q   <= 1'b0;
      mis_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbdata_q <= wbdata_d;
      strobe_q <= strobe_d;
      size_q   <= size_d;
      write_q  <= write_d;
      uns_q    <= uns_d;
      wben_q   <= wben_d;
      mis_q    <= mis_d;
      rd_q     <= rd_d;
    end
  end

  // Outputs decode registered state only; buses read zero outside their phase.
  assign in_ready    = (state_q == IDLE);
  assign dreq_valid  = (state_q == REQ);
  assign dreq_addr   = dreq_valid ? addr_q   : '0;
  assign dreq_write  = dreq_valid & write_q;
  assign dreq_size   = dreq_valid ? size_q   : 2'd0;
  assign dreq_wdata  = dreq_valid ? wdata_q  : '0;
  assign dreq_strobe = dreq_valid ? strobe_q : 8'd0;
  assign wb_valid    = (state_q == DONE);
  assign wb_en       = wb_valid & wben_q;
  assign wb_rd       = wb_valid ? rd_q     : '0;
  assign wb_data     = wb_valid ? wbdata_q : '0;
  assign misalign    = wb_valid & mis_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: reset, pass-through, loads, stores, stalls,
// misaligned accesses (behaviour follows LSU_MISALIGN_CHECK_EN).
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_out;
  logic [63:0] store_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  rd;
  logic        wb_en_in;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [1:0]  dreq_size;
  logic [63:0] dreq_wdata;
  logic [7:0]  dreq_strobe;
  logic        dresp_valid;
  logic [63:0] dresp_data;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .store_data(store_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd(rd), .wb_en_in(wb_en_in),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_write(dreq_write), .dreq_size(dreq_size), .dreq_wdata(dreq_wdata),
    .dreq_strobe(dreq_strobe),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // Runs one memory op with a bus responder. req_stall cycles of dreq_ready=0,
  // resp_stall cycles of dresp_valid=0. With poke set, in_valid (non-mem op)
  // and a junk dresp_valid are asserted while the stage is busy.
  task automatic mem_op(
    input  logic        r, w,
    input  logic [1:0]  sz,
    input  logic        u,
    input  logic [63:0] a, sd, rdata,
    input  int          req_stall, resp_stall,
    input  bit          poke,
    output int          lat, first_req,
    output logic [63:0] wbd, q_addr, q_wdata,
    output logic [7:0]  q_strb,
    output logic [1:0]  q_size,
    output logic [4:0]  wbrd,
    output logic        wbe, mis, q_wr, stable, seen);
    int nreq;
    int nresp;
    bit hs;
    mem_rd = r; mem_wr = w; mem_size = sz; mem_unsigned = u;
    alu_out = a; store_data = sd; rd = 5'd9; wb_en_in = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = poke;
    mem_rd = 1'b0; mem_wr = 1'b0; alu_out = 64'h0000_0000_0000_DEAD;
    lat = 1; first_req = 0; nreq = 0; nresp = 0; hs = 0;
    stable = 1'b1; seen = 1'b0; wbd = '0; wbe = 1'b0; mis = 1'b0; wbrd = '0;
    q_addr = '0; q_wdata = '0; q_strb = '0; q_size = '0; q_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      if (wb_valid) begin
        seen = 1'b1; wbd = wb_data; wbe = wb_en; mis = misalign; wbrd = wb_rd;
        in_valid = 1'b0;
        break;
      end
      if (dreq_valid) begin
        if (nreq == 0) begin
          first_req = lat; q_addr = dreq_addr; q_wdata = dreq_wdata;
          q_strb = dreq_strobe; q_size = dreq_size; q_wr = dreq_write;
        end else if (dreq_addr !== q_addr || dreq_wdata !== q_wdata ||
                     dreq_strobe !== q_strb || dreq_size !== q_size ||
                     dreq_write !== q_wr) begin
          stable = 1'b0;
        end
        dreq_ready = (nreq >= req_stall);
        nreq++;
        if (poke) begin
          dresp_valid = 1'b1; dresp_data = 64'h5555_5555_5555_5555;
        end
        if (dreq_ready) hs = 1;
      end else if (hs) begin
        dresp_valid = (nresp >= resp_stall);
        dresp_data  = rdata;
        nresp++;
      end
      tick;
      lat++;
    end
    dreq_ready = 1'b0; dresp_valid = 1'b0; in_valid = 1'b0;
  endtask

  int          lat, frq;
  logic [63:0] wbd, qa, qw;
  logic [7:0]  qs;
  logic [1:0]  qz;
  logic [4:0]  wrd;
  logic        wbe, mis, qwr, stb, seen;

  // After a beat: it must last one cycle and nothing else may have been accepted.
  task automatic post_beat(input string tag);
    tick;
    chk({tag, "_beat_1cyc"}, {63'd0, wb_valid}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_out = '0; store_data = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
    rd = '0; wb_en_in = 1'b0; dreq_ready = 1'b0; dresp_valid = 1'b0;
    dresp_data = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("rst_flags",     {57'd0, dreq_valid, dreq_write, wb_valid, wb_en, misalign, dreq_size}, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_wdata",     dreq_wdata, 64'd0);
    chk("rst_strobe",    {56'd0, dreq_strobe}, 64'd0);
    chk("rst_wb",        {59'd0, wb_rd} | wb_data, 64'd0);
    $display("txn reset: in_ready=%0b wb_valid=%0b", in_ready, wb_valid);

    // Reset while in WAIT: late response must be ignored.
    mem_rd = 1'b1; mem_size = 2'd3; alu_out = 64'h40; rd = 5'd3; wb_en_in = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0; mem_rd = 1'b0; dreq_ready = 1'b1;
    chk("midrst_req", {63'd0, dreq_valid}, 64'd1);
    tick;
    dreq_ready = 1'b0;
    chk("midrst_in_wait", {62'd0, in_ready, dreq_valid}, 64'd0);
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("midrst_idle",  {61'd0, in_ready, dreq_valid, wb_valid}, 64'd4);
    chk("midrst_addr",  dreq_addr, 64'd0);
    chk("midrst_wbd",   wb_data, 64'd0);
    dresp_valid = 1'b1; dresp_data = 64'h1234_5678_9ABC_DEF0;
    tick;
    dresp_valid = 1'b0;
    chk("late_resp_0", {63'd0, wb_valid}, 64'd0);
    tick;
    chk("late_resp_1", {63'd0, wb_valid}, 64'd0);
    $display("txn reset-in-wait: in_ready=%0b wb_valid=%0b", in_ready, wb_valid);

    // Non-memory pass-through.
    alu_out = 64'h1234; rd = 5'd7; wb_en_in = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("nm_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("nm_wb_rd",    {59'd0, wb_rd}, 64'd7);
    chk("nm_wb_data",  wb_data, 64'h1234);
    chk("nm_wb_en",    {63'd0, wb_en}, 64'd1);
    chk("nm_no_req",   {62'd0, dreq_valid, in_ready}, 64'd0);
    post_beat("nm");
    $display("txn nonmem: wb_data=%h", 64'h1234);

    // Load B signed at 0x1003.
    mem_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
    chk("lb_seen", {63'd0, seen}, 64'd1);
    chk("lb_first_req", lat == 0 ? 64'd99 : 64'(frq), 64'd1);
    chk("lb_lat", 64'(lat), 64'd3);
    chk("lb_addr", qa, 64'h1003);
    chk("lb_strobe", {56'd0, qs}, 64'h08);
    chk("lb_write", {63'd0, qwr}, 64'd0);
    chk("lb_data", wbd, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_wb_en", {59'd0, wrd, wbe}, {58'd0, 5'd9, 1'b1});
    post_beat("lb");
    $display("txn lb signed: wb_data=%h lat=%0d", wbd, lat);

    // Load B unsigned, same address and data.
    mem_op(1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
    chk("lbu_data", wbd, 64'h80);
    post_beat("lbu");
    $display("txn lbu: wb_data=%h", wbd);

    // Store H at 0x2006 with both mem_rd and mem_wr set (store wins).
    mem_op(1'b1, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 64'hFFFF_0000_FFFF_0000,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
    chk("sh_wdata", qw, 64'hABCD_0000_0000_0000);
    chk("sh_strobe", {56'd0, qs}, 64'hC0);
    chk("sh_write", {63'd0, qwr}, 64'd1);
    chk("sh_size", {62'd0, qz}, 64'd1);
    chk("sh_beat", {62'd0, seen, wbe}, 64'd2);
    chk("sh_wb_data", wbd, 64'd0);
    post_beat("sh");
    $display("txn sh: wdata=%h strobe=%h", qw, qs);

    // Load W signed with 3 request stalls and 2 response stalls, plus busy pokes.
    mem_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h10, 64'h77, 64'h1122_3344_89AB_CDEF,
           3, 2, 1'b1, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
    chk("stall_lat", 64'(lat), 64'd8);
    chk("stall_stable", {63'd0, stb}, 64'd1);
    chk("stall_strobe", {56'd0, qs}, 64'h0F);
    chk("stall_data", wbd, 64'hFFFF_FFFF_89AB_CDEF);
    post_beat("stall");
    tick;
    chk("stall_drop", {62'd0, wb_valid, dreq_valid}, 64'd0);
    $display("txn lw stalled: wb_data=%h lat=%0d", wbd, lat);

    // Load D passes all 64 bits.
    mem_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0102_0304_0506_0708, 64'h8000_0000_0000_0001,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
    chk("ld_data", wbd, 64'h8000_0000_0000_0001);
    chk("ld_strobe", {56'd0, qs}, 64'hFF);
    chk("ld_wdata", qw, 64'h0102_0304_0506_0708);
    post_beat("ld");
    $display("txn ld: wb_data=%h", wbd);

    // Misaligned W load at 0x1002 and misaligned H store at 0x7.
    mem_op(1'b1, 1'b0, 2'd2, 1'b1, 64'h1002, 64'd0, 64'h0000_1234_5678_0000,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_lw_lat", 64'(lat), 64'd1);
    chk("mis_lw_noreq", 64'(frq), 64'd0);
    chk("mis_lw_flags", {62'd0, mis, wbe}, 64'd2);
    chk("mis_lw_data", wbd, 64'h1002);
`else
    chk("mis_lw_lat", 64'(lat), 64'd3);
    chk("mis_lw_strobe", {56'd0, qs}, 64'h3C);
    chk("mis_lw_flags", {62'd0, mis, wbe}, 64'd1);
    chk("mis_lw_data", wbd, 64'h1234_5678);
`endif
    post_beat("mis_lw");
    $display("txn lw @1002: misalign=%0b wb_data=%h lat=%0d", mis, wbd, lat);

    mem_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h7, 64'hABCD, 64'd0,
           0, 0, 1'b0, lat, frq, wbd, qa, qw, qs, qz, wrd, wbe, mis, qwr, stb, seen);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_sh_lat", 64'(lat), 64'd1);
    chk("mis_sh_flags", {62'd0, mis, wbe}, 64'd2);
    chk("mis_sh_data", wbd, 64'h7);
`else
    chk("mis_sh_strobe", {56'd0, qs}, 64'h80);
    chk("mis_sh_wdata", qw, 64'hCD00_0000_0000_0000);
    chk("mis_sh_flags", {62'd0, mis, wbe}, 64'd0);
`endif
    post_beat("mis_sh");
    $display("txn sh @7: misalign=%0b strobe=%h", mis, qs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
